conv_frame_sequencer: RTL and testbench
=======================================

Name: conv_frame_sequencer

Overview:
- Processing-side address sequencer between the frame buffer memory controller and the convolution datapath (ALU + kernel ROM).
- On each frame-ready pulse it walks every pixel of the stored frame in raster order and drives `raddr_alu` to fetch the 3x3 window.
- It waits the memory read latency, then issues one `wen_alu` write of the ALU result to the same pixel address.
- It flags border pixels so the datapath can substitute pass-through data, and reports busy / frame-done / overrun status.

Parameters:
- H_RES, 320, pixels per line.
- V_RES, 240, lines per frame.
- AW, 17, address width; must satisfy 2^AW >= H_RES*V_RES.
- RD_LAT, 2, cycles from `raddr_alu` change to valid `rdata_alu`/`wdata_alu`; must be >= 1.

Ports:
- sys_clk, input, 1, processing clock (100 MHz domain).
- rst, input, 1, synchronous active-high reset.
- enable, input, 1, permits new frames to start; sampled only in IDLE.
- frame_start, input, 1, one-cycle pulse: a complete frame is available for processing.
- raddr_alu, output, AW, window-centre pixel address to the memory controller.
- waddr_alu, output, AW, write address for the ALU result.
- wen_alu, output, 1, write strobe, one cycle per pixel.
- border, output, 1, current write pixel has x=0, x=H_RES-1, y=0 or y=V_RES-1; valid while `wen_alu`=1.
- busy, output, 1, a frame is being processed.
- frame_done, output, 1, one-cycle pulse after the last pixel write.
- overrun, output, 1, sticky: a `frame_start` arrived while `busy`=1.

Behaviour:
- Reset (synchronous, sys_clk edge with `rst`=1):
  - FSM -> IDLE.
  - All outputs 0.
  - x, y, addr and wait counters 0.
  - Reset wins over every other event, including mid-frame; no further writes are issued.
- States: IDLE, ISSUE, WAIT, WRITE, DONE.
- IDLE:
  - `frame_start`=1 and `enable`=1 -> ISSUE; x=y=addr=0; `busy`=1 from the next cycle.
  - `frame_start` with `enable`=0 is ignored and does not set `overrun`.
- ISSUE (1 cycle): `raddr_alu`<=addr; wait counter<=0; -> WAIT.
- WAIT:
  - Lasts exactly RD_LAT cycles; `raddr_alu` is held; -> WRITE.
- WRITE (1 cycle):
  - `wen_alu`=1, `waddr_alu`=addr, `border` computed from x,y.
  - If addr = H_RES*V_RES-1 -> DONE.
  - Otherwise advance and -> ISSUE:
    - If x = H_RES-1: x<=0, y<=y+1.
    - Else: x<=x+1.
    - addr<=addr+1 in both cases.
- DONE (1 cycle): `frame_done`=1, `busy` still 1; -> IDLE (`busy`=0 in IDLE).
- Throughput and latency:
  - Each pixel takes RD_LAT+2 cycles.
  - The first `wen_alu` is RD_LAT+2 cycles after the `frame_start` sample edge.
- Address generation:
  - addr is a running counter; no multiplier.
  - x and y counters are sized to hold H_RES-1 and V_RES-1.
- `wen_alu`, `border` and `frame_done` are registered and are 0 in every cycle other than their state.
- `waddr_alu` and `border` hold their last values when `wen_alu`=0.
- `frame_start` while `busy`=1 (any non-IDLE state, including DONE):
  - Ignored; `overrun`<=1, cleared only by `rst`.
  - The current frame continues unaffected.
- `enable` deasserted mid-frame does not abort; the current frame completes.
- `frame_start` in the same cycle the FSM returns to IDLE (the DONE cycle) counts as overrun, not as a start.

Test Plan (H_RES=4, V_RES=3, AW=4, RD_LAT=2 unless noted):
- Basic frame: `enable`=1, `frame_start` pulse at cycle 0 -> 12 `wen_alu` pulses at cycles 4,8,...,48 with `waddr_alu`=0..11; `frame_done` at cycle 49; `busy` high for cycles 1-49.
- Border pattern: same run -> `border`=0 only for `waddr_alu` 5 and 6; 1 for the other 10 writes.
- Read/write alignment: check `raddr_alu`=N is stable from ISSUE through WRITE and `waddr_alu`=N on the matching strobe; repeat with RD_LAT=1 -> writes every 3 cycles, last at cycle 36.
- Overrun: second `frame_start` at cycle 20 -> `overrun`=1 from cycle 21 and stays 1; write sequence unchanged; no restart after `frame_done`.
- Gating: `enable`=0 with `frame_start` -> no writes, `busy`=0, `overrun`=0; `enable` dropped at cycle 10 after a valid start -> all 12 writes still occur.
- Reset mid-frame: `rst`=1 at cycle 22 -> from the next cycle all outputs 0 and no `wen_alu`; a new `frame_start` restarts at `waddr_alu`=0.

Source files
------------

// File: rtl/conv_frame_sequencer.sv
// Address sequencer for the convolution datapath: walks a stored frame in raster order,
// issuing one read per pixel, waiting out the memory latency, then writing the ALU result back.
module conv_frame_sequencer #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int AW     = 17,
  parameter int RD_LAT = 2
) (
  input  logic          sys_clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          frame_start,
  output logic [AW-1:0] raddr_alu,
  output logic [AW-1:0] waddr_alu,
  output logic          wen_alu,
  output logic          border,
  output logic          busy,
  output logic          frame_done,
  output logic          overrun
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int WW = $clog2(RD_LAT + 1);
  localparam logic [XW-1:0] X_LAST    = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(V_RES - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(H_RES * V_RES - 1);
  localparam logic [WW-1:0] W_LAST    = WW'(RD_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          wen_q, wen_d;
  logic          border_q, border_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          overrun_q, overrun_d;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      wcnt_q    <= '0;
      raddr_q   <= '0;
      waddr_q   <= '0;
      wen_q     <= 1'b0;
      border_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      addr_q    <= addr_d;
      wcnt_q    <= wcnt_d;
      raddr_q   <= raddr_d;
      waddr_q   <= waddr_d;
      wen_q     <= wen_d;
      border_q  <= border_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    addr_d    = addr_q;
    wcnt_d    = wcnt_q;
    raddr_d   = raddr_q;
    waddr_d   = waddr_q;
    border_d  = border_q;
    overrun_d = overrun_q;

    case (state_q)
      S_IDLE: begin
        if (frame_start && enable) begin
          state_d = S_ISSUE;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
        end
      end
      S_ISSUE: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == W_LAST) state_d = S_WRITE;
        else                  wcnt_d  = wcnt_q + 1'b1;
      end
      S_WRITE: begin
        if (addr_q == ADDR_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
          addr_d  = addr_q + 1'b1;
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they belong to.
    busy_d = (state_d != S_IDLE);
    wen_d  = (state_d == S_WRITE);
    done_d = (state_d == S_DONE);
    if (state_d == S_ISSUE) raddr_d = addr_d;
    if (state_d == S_WRITE) begin
      waddr_d  = addr_q;
      border_d = (x_q == '0) || (x_q == X_LAST) || (y_q == '0) || (y_q == Y_LAST);
    end
    if (frame_start && (state_q != S_IDLE)) overrun_d = 1'b1;
  end

  assign raddr_alu  = raddr_q;
  assign waddr_alu  = waddr_q;
  assign wen_alu    = wen_q;
  assign border     = border_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer on a 4x3 frame, RD_LAT=2 (dut) and RD_LAT=1 (dut1).
module tb_conv_frame_sequencer;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       frame_start = 1'b0;
  logic [3:0] raddr_alu, waddr_alu, raddr_1, waddr_1;
  logic       wen_alu, border, busy, frame_done, overrun;
  logic       wen_1, border_1, busy_1, done_1, overrun_1;

  int total = 0;
  int bad   = 0;

  localparam int NC = 64;
  logic [3:0] s_raddr [NC];
  logic [3:0] s_waddr [NC];
  logic       s_wen [NC], s_border [NC], s_busy [NC], s_done [NC], s_ovr [NC];
  logic [3:0] t_raddr [NC];
  logic [3:0] t_waddr [NC];
  logic       t_wen [NC], t_busy [NC], t_done [NC];

  always #5 sys_clk = ~sys_clk;

  conv_frame_sequencer #(.H_RES(4), .V_RES(3), .AW(4), .RD_LAT(2)) dut (
    .sys_clk(sys_clk), .rst(rst), .enable(enable), .frame_start(frame_start),
    .raddr_alu(raddr_alu), .waddr_alu(waddr_alu), .wen_alu(wen_alu), .border(border),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  conv_frame_sequencer #(.H_RES(4), .V_RES(3), .AW(4), .RD_LAT(1)) dut1 (
    .sys_clk(sys_clk), .rst(rst), .enable(enable), .frame_start(frame_start),
    .raddr_alu(raddr_1), .waddr_alu(waddr_1), .wen_alu(wen_1), .border(border_1),
    .busy(busy_1), .frame_done(done_1), .overrun(overrun_1)
  );

  task automatic do_reset();
    @(negedge sys_clk);
    rst = 1'b1; frame_start = 1'b0; enable = 1'b0;
    @(negedge sys_clk);
    rst = 1'b0;
  endtask

  // Cycle 0 carries the start pulse; cycle c is sampled mid-cycle, then inputs for cycle c are applied.
  task automatic capture(input int ncyc, input bit en0, input int fs2, input int en_drop, input int rst_c);
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) @(negedge sys_clk);
      s_raddr[c] = raddr_alu; s_waddr[c] = waddr_alu; s_wen[c] = wen_alu; s_border[c] = border;
      s_busy[c] = busy; s_done[c] = frame_done; s_ovr[c] = overrun;
      t_raddr[c] = raddr_1; t_waddr[c] = waddr_1; t_wen[c] = wen_1; t_busy[c] = busy_1; t_done[c] = done_1;
      frame_start = (c == 0) || (c == fs2);
      enable      = en0 && !(en_drop >= 0 && c >= en_drop);
      rst         = (c == rst_c);
    end
    @(negedge sys_clk);
    frame_start = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge sys_clk);
    rst = 1'b1;
    @(negedge sys_clk);
    total++;
    if ({raddr_alu, waddr_alu, wen_alu, border, busy, frame_done, overrun} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {raddr_alu, waddr_alu, wen_alu, border, busy, frame_done, overrun});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    int n;
    do_reset();
    capture(56, 1'b1, -1, -1, -1);
    for (int c = 0; c < 56; c++) begin
      logic ew, eb, ed;
      ew = (c >= 4) && (c <= 48) && (c % 4 == 0);
      eb = (c >= 1) && (c <= 49);
      ed = (c == 49);
      total += 3;
      if (s_wen[c] !== ew)  begin bad++; $display("FAIL basic_wen c=%0d got=%b want=%b", c, s_wen[c], ew); end
      if (s_busy[c] !== eb) begin bad++; $display("FAIL basic_busy c=%0d got=%b want=%b", c, s_busy[c], eb); end
      if (s_done[c] !== ed) begin bad++; $display("FAIL basic_done c=%0d got=%b want=%b", c, s_done[c], ed); end
      if (ew) begin
        n = c / 4 - 1;
        total += 2;
        if (s_waddr[c] !== 4'(n)) begin bad++; $display("FAIL basic_waddr c=%0d got=%0d want=%0d", c, s_waddr[c], n); end
        if (s_border[c] !== (n != 5 && n != 6)) begin
          bad++; $display("FAIL basic_border addr=%0d got=%b want=%b", n, s_border[c], (n != 5 && n != 6));
        end
        for (int k = c - 3; k <= c; k++) begin
          total++;
          if (s_raddr[k] !== 4'(n)) begin bad++; $display("FAIL basic_raddr c=%0d got=%0d want=%0d", k, s_raddr[k], n); end
        end
      end
    end
    total++;
    if (s_ovr[55] !== 1'b0) begin bad++; $display("FAIL basic_overrun got=%b want=0", s_ovr[55]); end
  endtask

  task automatic test_rdlat1();
    int n;
    do_reset();
    capture(42, 1'b1, -1, -1, -1);
    for (int c = 0; c < 42; c++) begin
      logic ew;
      ew = (c >= 3) && (c <= 36) && (c % 3 == 0);
      total += 3;
      if (t_wen[c] !== ew) begin bad++; $display("FAIL lat1_wen c=%0d got=%b want=%b", c, t_wen[c], ew); end
      if (t_done[c] !== (c == 37)) begin bad++; $display("FAIL lat1_done c=%0d got=%b want=%b", c, t_done[c], c == 37); end
      if (t_busy[c] !== (c >= 1 && c <= 37)) begin bad++; $display("FAIL lat1_busy c=%0d got=%b", c, t_busy[c]); end
      if (ew) begin
        n = c / 3 - 1;
        total++;
        if (t_waddr[c] !== 4'(n)) begin bad++; $display("FAIL lat1_waddr c=%0d got=%0d want=%0d", c, t_waddr[c], n); end
        for (int k = c - 2; k <= c; k++) begin
          total++;
          if (t_raddr[k] !== 4'(n)) begin bad++; $display("FAIL lat1_raddr c=%0d got=%0d want=%0d", k, t_raddr[k], n); end
        end
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    capture(62, 1'b1, 20, -1, -1);
    for (int c = 0; c < 62; c++) begin
      logic ew;
      ew = (c >= 4) && (c <= 48) && (c % 4 == 0);
      total += 3;
      if (s_ovr[c] !== (c >= 21)) begin bad++; $display("FAIL ovr_flag c=%0d got=%b want=%b", c, s_ovr[c], c >= 21); end
      if (s_wen[c] !== ew) begin bad++; $display("FAIL ovr_wen c=%0d got=%b want=%b", c, s_wen[c], ew); end
      if (s_busy[c] !== (c >= 1 && c <= 49)) begin bad++; $display("FAIL ovr_busy c=%0d got=%b", c, s_busy[c]); end
      if (ew) begin
        total++;
        if (s_waddr[c] !== 4'(c / 4 - 1)) begin bad++; $display("FAIL ovr_waddr c=%0d got=%0d want=%0d", c, s_waddr[c], c / 4 - 1); end
      end
    end
  endtask

  task automatic test_gating();
    int writes;
    do_reset();
    capture(20, 1'b0, -1, -1, -1);
    for (int c = 0; c < 20; c++) begin
      total++;
      if ({s_wen[c], s_busy[c], s_ovr[c]} !== 3'b000) begin
        bad++; $display("FAIL gate_off c=%0d got=%b want=000", c, {s_wen[c], s_busy[c], s_ovr[c]});
      end
    end
    do_reset();
    capture(56, 1'b1, -1, 10, -1);
    writes = 0;
    for (int c = 0; c < 56; c++) if (s_wen[c] === 1'b1) writes++;
    total += 3;
    if (writes != 12) begin bad++; $display("FAIL gate_drop_writes got=%0d want=12", writes); end
    if (s_done[49] !== 1'b1) begin bad++; $display("FAIL gate_drop_done got=%b want=1", s_done[49]); end
    if (s_waddr[48] !== 4'd11) begin bad++; $display("FAIL gate_drop_last got=%0d want=11", s_waddr[48]); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    capture(40, 1'b1, -1, -1, 22);
    for (int c = 23; c < 40; c++) begin
      total++;
      if ({s_raddr[c], s_waddr[c], s_wen[c], s_border[c], s_busy[c], s_done[c], s_ovr[c]} !== 13'd0) begin
        bad++;
        $display("FAIL rst_mid c=%0d got=%h want=0", c,
                 {s_raddr[c], s_waddr[c], s_wen[c], s_border[c], s_busy[c], s_done[c], s_ovr[c]});
      end
    end
    capture(10, 1'b1, -1, -1, -1);
    total += 3;
    if (s_wen[4] !== 1'b1) begin bad++; $display("FAIL rst_restart_wen got=%b want=1", s_wen[4]); end
    if (s_waddr[4] !== 4'd0) begin bad++; $display("FAIL rst_restart_waddr got=%0d want=0", s_waddr[4]); end
    if (s_wen[8] !== 1'b1 || s_waddr[8] !== 4'd1) begin
      bad++; $display("FAIL rst_restart_second got=%b/%0d want=1/1", s_wen[8], s_waddr[8]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_rdlat1();
    test_overrun();
    test_gating();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
